// File: rtl/u_mem_pkg.sv
// Shared types and op-code helpers for the memory-stage access sequencer.
package u_mem_pkg;

    typedef enum logic [3:0] {
        MOP_NOP = 4'd0,
        MOP_LB  = 4'd1,
        MOP_LBU = 4'd2,
        MOP_LH  = 4'd3,
        MOP_LHU = 4'd4,
        MOP_LW  = 4'd5,
        MOP_SB  = 4'd6,
        MOP_SH  = 4'd7,
        MOP_SW  = 4'd8
    } mem_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        HALF2 = 1'b1
    } mac_state_e;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/u_load_ext.sv
// Sign/zero extension of a byte or halfword load result to 32 bits.
module u_load_ext (
    input  logic [15:0] data,
    input  logic        size_half,
    input  logic        sign_ext,
    output logic [31:0] result
);

    // select width and extension mode
    always_comb begin
        result = 32'd0;
        if (size_half) begin
            if (sign_ext) begin
                result = {{16{data[15]}}, data};
            end else begin
                result = {16'd0, data};
            end
        end else begin
            if (sign_ext) begin
                result = {{24{data[7]}}, data[7:0]};
            end else begin
                result = {24'd0, data[7:0]};
            end
        end
    end

endmodule

// File: rtl/u_mem_access_ctrl.sv
// Memory-stage sequencer: maps MIPS load/store ops onto a word/byte data memory
// port, splitting halfwords into two byte accesses with a one-cycle stall.
module u_mem_access_ctrl
    import u_mem_pkg::*;
(
    input  logic        i_sys_clock,
    input  logic        i_sys_rst_n,
    input  logic        i_u_mem_access_ctrl_valid,
    input  logic [3:0]  i_u_mem_access_ctrl_op,
    input  logic [31:0] i_u_mem_access_ctrl_addr,
    input  logic [31:0] i_u_mem_access_ctrl_wdata,
    input  logic [31:0] i_u_mem_access_ctrl_dm_rdata,
    output logic [31:0] o_u_mem_access_ctrl_dm_addr,
    output logic [31:0] o_u_mem_access_ctrl_dm_wdata,
    output logic        o_u_mem_access_ctrl_dm_wr,
    output logic        o_u_mem_access_ctrl_dm_word,
    output logic        o_u_mem_access_ctrl_stall,
    output logic [31:0] o_u_mem_access_ctrl_rdata,
    output logic        o_u_mem_access_ctrl_rdata_valid,
    output logic        o_u_mem_access_ctrl_misalign
);

    mac_state_e  state_r, next_state_s;
    logic [31:0] hold_addr_r;
    logic [7:0]  hold_byte_r;
    logic [3:0]  hold_op_r;

    logic        valid_s;
    logic [3:0]  op_s;
    logic [31:0] addr_s;
    logic [31:0] dm_rdata_s;

    logic [31:0] dm_addr_s, dm_wdata_s, rdata_s;
    logic        dm_wr_s, dm_word_s, stall_s, rdata_valid_s, misalign_s, capture_s;

    logic [15:0] ext_data_s;
    logic        ext_half_s, ext_signed_s;
    logic [31:0] ext_result_s;

    assign valid_s    = i_u_mem_access_ctrl_valid;
    assign op_s       = i_u_mem_access_ctrl_op;
    assign addr_s     = i_u_mem_access_ctrl_addr;
    assign dm_rdata_s = i_u_mem_access_ctrl_dm_rdata;

    // The second half of a halfword load pairs the fresh byte with the held low byte
    assign ext_half_s   = (state_r == HALF2);
    assign ext_data_s   = (state_r == HALF2) ? {dm_rdata_s[7:0], hold_byte_r}
                                             : {8'd0, dm_rdata_s[7:0]};
    assign ext_signed_s = (state_r == HALF2) ? (hold_op_r == OP_LH) : (op_s == OP_LB);

    u_load_ext u_ext (
        .data      (ext_data_s),
        .size_half (ext_half_s),
        .sign_ext  (ext_signed_s),
        .result    (ext_result_s)
    );

    // next-state and memory-port decode
    always_comb begin
        next_state_s  = state_r;
        dm_addr_s     = addr_s;
        dm_wdata_s    = i_u_mem_access_ctrl_wdata;
        dm_wr_s       = 1'b0;
        dm_word_s     = 1'b1;
        stall_s       = 1'b0;
        rdata_s       = 32'd0;
        rdata_valid_s = 1'b0;
        misalign_s    = 1'b0;
        capture_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid_s && is_word(op_s)) begin
                    if (addr_s[1:0] != 2'b00) begin
                        misalign_s = 1'b1;
                    end else if (op_s == OP_SW) begin
                        dm_wr_s = 1'b1;
                    end else begin
                        rdata_s       = dm_rdata_s;
                        rdata_valid_s = 1'b1;
                    end
                end else if (valid_s && is_half(op_s)) begin
                    dm_word_s    = 1'b0;
                    stall_s      = 1'b1;
                    capture_s    = 1'b1;
                    dm_wr_s      = (op_s == OP_SH);
                    next_state_s = HALF2;
                end else if (valid_s && ((op_s == OP_LB) || (op_s == OP_LBU))) begin
                    dm_word_s     = 1'b0;
                    rdata_s       = ext_result_s;
                    rdata_valid_s = 1'b1;
                end else if (valid_s && (op_s == OP_SB)) begin
                    dm_word_s = 1'b0;
                    dm_wr_s   = 1'b1;
                end else begin
                    dm_word_s = 1'b1;
                end
            end
            HALF2: begin
                dm_addr_s    = hold_addr_r;
                dm_word_s    = 1'b0;
                dm_wdata_s   = {24'd0, hold_byte_r};
                next_state_s = IDLE;
                if (hold_op_r == OP_SH) begin
                    dm_wr_s = 1'b1;
                end else begin
                    rdata_s       = ext_result_s;
                    rdata_valid_s = 1'b1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // state and halfword hold registers
    always_ff @(posedge i_sys_clock or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_r     <= IDLE;
            hold_addr_r <= 32'd0;
            hold_byte_r <= 8'd0;
            hold_op_r   <= OP_NOP;
        end else begin
            state_r <= next_state_s;
            if (capture_s) begin
                hold_addr_r <= addr_s + 32'd1;
                hold_op_r   <= op_s;
                hold_byte_r <= is_load(op_s) ? dm_rdata_s[7:0]
                                             : i_u_mem_access_ctrl_wdata[15:8];
            end
        end
    end

    // Control outputs are forced quiet for as long as reset is held
    assign o_u_mem_access_ctrl_dm_addr     = dm_addr_s;
    assign o_u_mem_access_ctrl_dm_wdata    = dm_wdata_s;
    assign o_u_mem_access_ctrl_dm_word     = dm_word_s;
    assign o_u_mem_access_ctrl_dm_wr       = i_sys_rst_n & dm_wr_s;
    assign o_u_mem_access_ctrl_stall       = i_sys_rst_n & stall_s;
    assign o_u_mem_access_ctrl_rdata       = i_sys_rst_n ? rdata_s : 32'd0;
    assign o_u_mem_access_ctrl_rdata_valid = i_sys_rst_n & rdata_valid_s;
    assign o_u_mem_access_ctrl_misalign    = i_sys_rst_n & misalign_s;

endmodule

// File: tb/tb_u_mem_access_ctrl.sv
// Self-checking bench for u_mem_access_ctrl with a byte-array data memory model.
module tb_u_mem_access_ctrl;
    import u_mem_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        rv;
        logic        stall;
        logic        wr;
        logic        mis;
        logic        word;
        logic [31:0] addr;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] dm_rdata;
    logic [31:0] dm_addr, dm_wdata, rdata;
    logic        dm_wr, dm_word, stall, rdata_valid, misalign;

    logic [7:0]  mem [0:63];
    obs_t        exp_q[$];
    obs_t        got, want;
    int          n_checks = 0;
    int          n_fails = 0;

    u_mem_access_ctrl dut (
        .i_sys_clock                     (clk),
        .i_sys_rst_n                     (rst_n),
        .i_u_mem_access_ctrl_valid       (valid),
        .i_u_mem_access_ctrl_op          (op),
        .i_u_mem_access_ctrl_addr        (addr),
        .i_u_mem_access_ctrl_wdata       (wdata),
        .i_u_mem_access_ctrl_dm_rdata    (dm_rdata),
        .o_u_mem_access_ctrl_dm_addr     (dm_addr),
        .o_u_mem_access_ctrl_dm_wdata    (dm_wdata),
        .o_u_mem_access_ctrl_dm_wr       (dm_wr),
        .o_u_mem_access_ctrl_dm_word     (dm_word),
        .o_u_mem_access_ctrl_stall       (stall),
        .o_u_mem_access_ctrl_rdata       (rdata),
        .o_u_mem_access_ctrl_rdata_valid (rdata_valid),
        .o_u_mem_access_ctrl_misalign    (misalign)
    );

    always #5 clk = ~clk;

    // combinational read port: word access returns aligned word, byte access returns byte in [7:0]
    always_comb begin
        if (dm_word) begin
            dm_rdata = {mem[{dm_addr[5:2], 2'b11}], mem[{dm_addr[5:2], 2'b10}],
                        mem[{dm_addr[5:2], 2'b01}], mem[{dm_addr[5:2], 2'b00}]};
        end else begin
            dm_rdata = {24'd0, mem[dm_addr[5:0]]};
        end
    end

    always @(posedge clk) begin
        if (dm_wr) begin
            if (dm_word) begin
                mem[{dm_addr[5:2], 2'b00}] <= dm_wdata[7:0];
                mem[{dm_addr[5:2], 2'b01}] <= dm_wdata[15:8];
                mem[{dm_addr[5:2], 2'b10}] <= dm_wdata[23:16];
                mem[{dm_addr[5:2], 2'b11}] <= dm_wdata[31:24];
            end else begin
                mem[dm_addr[5:0]] <= dm_wdata[7:0];
            end
        end
    end

    function automatic obs_t ex(input logic [31:0] r, input logic v, input logic s,
                                input logic w, input logic m, input logic wd,
                                input logic [31:0] a);
        ex = '{rdata: r, rv: v, stall: s, wr: w, mis: m, word: wd, addr: a};
    endfunction

    function automatic obs_t sample();
        sample = '{rdata: rdata, rv: rdata_valid, stall: stall, wr: dm_wr,
                   mis: misalign, word: dm_word, addr: dm_addr};
    endfunction

    task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] wd);
        @(posedge clk);
        #1;
        valid = v;
        op    = o;
        addr  = a;
        wdata = wd;
    endtask

    task automatic test_reset();
        valid = 1'b1; op = OP_LW; addr = 32'd0; wdata = 32'd0;
        exp_q.push_back(ex(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0));
        @(negedge clk);
        got = sample(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fails++; $display("FAIL reset_lw: got %h expected %h", got, want);
        end
        op = OP_SW; wdata = 32'hFFFF_FFFF;
        exp_q.push_back(ex(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0));
        @(negedge clk);
        got = sample(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fails++; $display("FAIL reset_sw: got %h expected %h", got, want);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (mem[0] !== 8'hBB) begin
            n_fails++; $display("FAIL reset_mem: got %h expected bb", mem[0]);
        end
        rst_n = 1'b1; valid = 1'b0; op = OP_NOP;
    endtask

    task automatic test_word();
        logic [3:0]  ops [3] = '{OP_LW, OP_SW, OP_LW};
        logic [31:0] adr [3] = '{32'h0, 32'h8, 32'h8};
        exp_q.push_back(ex(32'h8899_AABB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0));
        exp_q.push_back(ex(32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8));
        exp_q.push_back(ex(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], adr[i], 32'hDEAD_BEEF);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fails++; $display("FAIL word step %0d: got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_bytes();
        logic [3:0]  ops [4] = '{OP_LB, OP_LBU, OP_SB, OP_LB};
        logic [31:0] adr [4] = '{32'h1, 32'h1, 32'h20, 32'h20};
        exp_q.push_back(ex(32'hFFFF_FFAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1));
        exp_q.push_back(ex(32'h0000_00AA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1));
        exp_q.push_back(ex(32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20));
        exp_q.push_back(ex(32'hFFFF_FFAB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], adr[i], 32'h1234_56AB);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fails++; $display("FAIL bytes step %0d: got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_half_loads();
        logic [3:0] ops [4] = '{OP_LH, OP_LH, OP_LHU, OP_LHU};
        exp_q.push_back(ex(32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2));
        exp_q.push_back(ex(32'hFFFF_8899, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3));
        exp_q.push_back(ex(32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2));
        exp_q.push_back(ex(32'h0000_8899, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], 32'h2, 32'd0);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fails++; $display("FAIL half_load step %0d: got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_sh_cross();
        exp_q.push_back(ex(32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3));
        exp_q.push_back(ex(32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4));
        exp_q.push_back(ex(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3));
        for (int i = 0; i < 3; i++) begin
            drive(i < 2, (i < 2) ? OP_SH : OP_NOP, 32'h3, 32'h0000_1234);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fails++; $display("FAIL sh_cross step %0d: got %h expected %h", i, got, want);
            end
        end
        n_checks++;
        if (mem[3] !== 8'h34) begin
            n_fails++; $display("FAIL sh_cross_lo: got %h expected 34", mem[3]);
        end
        n_checks++;
        if (mem[4] !== 8'h12) begin
            n_fails++; $display("FAIL sh_cross_hi: got %h expected 12", mem[4]);
        end
    endtask

    task automatic test_misalign();
        logic [7:0] snap [4];
        for (int k = 0; k < 4; k++) snap[k] = mem[4 + k];
        exp_q.push_back(ex(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h6));
        exp_q.push_back(ex(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5));
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, (i == 0) ? OP_SW : OP_LW, (i == 0) ? 32'h6 : 32'h5, 32'hFFFF_FFFF);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fails++; $display("FAIL misalign step %0d: got %h expected %h", i, got, want);
            end
        end
        drive(1'b0, OP_NOP, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (mem[4 + k] !== snap[k]) begin
                n_fails++; $display("FAIL misalign_mem byte %0d: got %h expected %h", 4 + k, mem[4 + k], snap[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [4] = '{OP_SH, OP_SH, OP_LHU, OP_LHU};
        exp_q.push_back(ex(32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10));
        exp_q.push_back(ex(32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h11));
        exp_q.push_back(ex(32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10));
        exp_q.push_back(ex(32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], 32'h10, 32'h0000_1234);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fails++; $display("FAIL back_to_back step %0d: got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_in_half2();
        drive(1'b1, OP_SH, 32'h18, 32'h0000_5678);
        exp_q.push_back(ex(32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h18));
        @(negedge clk);
        got = sample(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fails++; $display("FAIL rst_half2 issue: got %h expected %h", got, want);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.push_back(ex(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h18));
        @(negedge clk);
        got = sample(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fails++; $display("FAIL rst_half2 abort: got %h expected %h", got, want);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (mem[24] !== 8'h78) begin
            n_fails++; $display("FAIL rst_half2_lo: got %h expected 78", mem[24]);
        end
        n_checks++;
        if (mem[25] !== 8'h00) begin
            n_fails++; $display("FAIL rst_half2_hi: got %h expected 00", mem[25]);
        end
        rst_n = 1'b1; valid = 1'b0; op = OP_NOP;
        exp_q.push_back(ex(32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h18));
        exp_q.push_back(ex(32'h0000_0078, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h19));
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, OP_LHU, 32'h18, 32'd0);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fails++; $display("FAIL rst_half2 reload step %0d: got %h expected %h", i, got, want);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 8'h00;
        mem[0] = 8'hBB; mem[1] = 8'hAA; mem[2] = 8'h99; mem[3] = 8'h88;
        test_reset();
        test_word();
        test_bytes();
        test_half_loads();
        test_sh_cross();
        test_misalign();
        test_back_to_back();
        test_reset_in_half2();
        drive(1'b0, OP_NOP, 32'h0, 32'h0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/u_mem_access_ctrl.md
# u_mem_access_ctrl

Memory-stage access sequencer between the EX/MEM pipeline register and the data memory (word/byte port only, combinational read, posedge write). Decodes MIPS load/store ops (LB/LBU/LH/LHU/LW/SB/SH/SW) into one or two memory accesses. Halfwords are split into two byte accesses over two cycles, with a pipeline stall. Loads are returned sign- or zero-extended. Misaligned word accesses are flagged and suppressed.

## Interface
- No parameters; data width fixed at 32, little-endian byte order (byte 0 = bits 7:0).
- i_sys_clock  in  1  single clock, all state on rising edge.
- i_sys_rst_n  in  1  asynchronous, active-low reset.
- i_u_mem_access_ctrl_valid  in  1  memory op present this cycle.
- i_u_mem_access_ctrl_op  in  4  op code, mem_op_e: 0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NOP.
- i_u_mem_access_ctrl_addr  in  32  byte address from ALU.
- i_u_mem_access_ctrl_wdata  in  32  store data (rt).
- i_u_mem_access_ctrl_dm_rdata  in  32  data memory read port.
- o_u_mem_access_ctrl_dm_addr  out  32  address to data memory.
- o_u_mem_access_ctrl_dm_wdata  out  32  write data to data memory.
- o_u_mem_access_ctrl_dm_wr  out  1  data memory write enable.
- o_u_mem_access_ctrl_dm_word  out  1  1 = word access, 0 = byte access.
- o_u_mem_access_ctrl_stall  out  1  freeze upstream pipeline; inputs held stable.
- o_u_mem_access_ctrl_rdata  out  32  extended load result.
- o_u_mem_access_ctrl_rdata_valid  out  1  rdata is a completed load this cycle.
- o_u_mem_access_ctrl_misalign  out  1  LW/SW with addr[1:0] != 0 this cycle.

## Operation
- States (mac_state_e): IDLE, HALF2.
- IDLE, no valid/NOP: dm_wr=0, dm_word=1, dm_addr=addr, outputs low, rdata=0.
- IDLE, LW/SW, addr[1:0]==0: one word access. dm_word=1. SW drives dm_wr=1, dm_wdata=wdata. LW drives rdata=dm_rdata, rdata_valid=1. No stall.
- IDLE, LW/SW, addr[1:0]!=0: misalign=1, dm_wr=0, rdata=0, rdata_valid=0. Stay IDLE; no memory change.
- IDLE, LB/LBU: byte access. rdata = sign- or zero-extended dm_rdata[7:0]; rdata_valid=1.
- IDLE, SB: byte access. dm_wr=1, dm_wdata=wdata.
- IDLE, LH/LHU/SH, any alignment (word crossing allowed):
  - Issue byte access at addr; stall=1.
  - Register hold_addr = addr+1 (32-bit wrap, 0xFFFFFFFF -> 0).
  - Register hold_op = op.
  - SH: write wdata[7:0] and register hold_byte = wdata[15:8].
  - LH/LHU: register hold_byte = dm_rdata[7:0].
  - Next state HALF2.
- HALF2: byte access at hold_addr; stall=0; current inputs ignored.
  - SH: dm_wr=1, dm_wdata={24'b0, hold_byte}.
  - LH/LHU: rdata = ext16({dm_rdata[7:0], hold_byte}); rdata_valid=1.
  - Next state IDLE.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.

## Timing
- Reset (async assert, sync release to IDLE): state=IDLE, hold_addr=0, hold_byte=0, hold_op=NOP.
- While reset is asserted: stall=0, dm_wr=0, rdata=0, rdata_valid=0, misalign=0.
- Reset in HALF2 aborts the op. First SH byte stays written; second is never written.
- Word/byte ops: 0-cycle added latency. Load result is combinational in the issue cycle; store commits at that cycle's rising edge.
- Halfword ops: 2 cycles; stall high exactly 1 cycle.
  - SH: low byte commits at the end of cycle 1, high byte at the end of cycle 2.
  - LH/LHU: result valid in cycle 2 only.
- Upstream holds valid/op/addr/wdata while stall=1. Block relies only on registered copies in HALF2.
- Back-to-back halfword ops: the new op is accepted in the IDLE cycle directly after HALF2; no bubble.

## Structure
- Package u_mem_pkg holds:
  - mem_op_e (4-bit);
  - mac_state_e;
  - localparam OP_NOP..OP_SW;
  - helper predicate functions is_load / is_half / is_word.
- One combinational sub-module, u_load_ext: inputs 16-bit data, size (byte/half), signed flag; output 32-bit result.
- FSM, hold registers and output mux stay in u_mem_access_ctrl.

## Test plan
- Memory word 0 = 0x8899AABB; LW addr 0x0 -> rdata 0x8899AABB, rdata_valid=1, stall never high.
- LB addr 0x1 -> rdata 0xFFFFFFAA; LBU addr 0x1 -> 0x000000AA; LH addr 0x2 -> 0xFFFF8899; LHU addr 0x2 -> 0x00008899, stall high one cycle.
- SH wdata 0x1234 addr 0x3 (crossing) -> memory word 0 bits 31:24 = 0x34, word 1 bits 7:0 = 0x12. dm_wr high two consecutive cycles; addresses 0x3 then 0x4.
- SW addr 0x6 -> misalign=1, dm_wr=0, memory unchanged; LW addr 0x5 -> misalign=1, rdata=0.
- SH then LHU back-to-back to the same address 0x10 -> LHU returns the stored 0x1234; stall pattern 1,0,1,0.
- Assert i_sys_rst_n low in HALF2 of an SH -> state IDLE immediately, stall=0, dm_wr=0, only the low byte written.
